// File: rtl/imem_loader.sv
// imem_loader: encodes MIPS R-type field bundles and writes them, one word per cycle,
// into consecutive instruction-memory byte addresses starting at BASE_ADDR.
module imem_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:4]  in_rs,
  input  logic [0:4]  in_rt,
  input  logic [0:4]  in_rd,
  input  logic [0:5]  in_funct,
  input  logic        in_last,
  output logic        mem_we,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_wdata,
  output logic [0:15] count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_LOAD  = 2'd1;
  localparam logic [1:0]  S_DONE  = 2'd2;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  function automatic logic is_legal_funct(input logic [0:5] f);
    logic ok;
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b100111, 6'b101010: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [0:31] encode_rtype(input logic [0:4] rs, input logic [0:4] rt,
                                               input logic [0:4] rd, input logic [0:5] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [0:31] addr_q,  addr_d;
  logic [0:31] wdata_q, wdata_d;
  logic        we_q,    we_d;
  logic        ready_q, ready_d;
  logic        err_q,   err_d;
  // fin_q: the final bundle (in_last or DEPTH-th word) has been taken; DONE follows next edge
  logic        fin_q,   fin_d;
  logic        accept_s;
  logic        legal_s;

  assign accept_s = in_valid && ready_q;
  assign legal_s  = is_legal_funct(in_funct);

  // Next-state logic for the session FSM, write port and counters
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    fin_d   = fin_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = 16'd0;
          err_d   = 1'b0;
          fin_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (fin_q) begin
          state_d = S_DONE;
          fin_d   = 1'b0;
        end else if (accept_s) begin
          if (legal_s) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, count_q, 2'b00};
            wdata_d = encode_rtype(in_rs, in_rt, in_rd, in_funct);
            count_d = count_q + 16'd1;
          end else begin
            err_d   = 1'b1;
          end
          fin_d = in_last || (legal_s && (({1'b0, count_q} + 17'd1) == DEPTH_W));
        end else begin
          fin_d = fin_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_LOAD) && !fin_d;
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 16'd0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
    end
  end

  assign in_ready  = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign busy      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: default instance (DEPTH=64, base 0) plus a
// DEPTH=4 instance at base 0x1000 for the full-memory case.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start, start4;
  logic        in_valid, in_valid4;
  logic [0:4]  in_rs, in_rt, in_rd;
  logic [0:5]  in_funct;
  logic        in_last;
  logic        in_ready, in_ready4;
  logic        mem_we, mem_we4;
  logic [0:31] mem_addr, mem_addr4, mem_wdata, mem_wdata4;
  logic [0:15] count, count4;
  logic        busy, busy4, done, done4, err, err4;

  int vectors;
  int miscompares;

  logic [4:0]  tb_rs    [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31};
  logic [4:0]  tb_rt    [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd30};
  logic [4:0]  tb_rd    [6] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd29};
  logic [5:0]  tb_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [31:0] tb_word  [6] = '{32'h0001_1020, 32'h0022_1822, 32'h0043_2024,
                                32'h0064_2825, 32'h0085_3027, 32'h03FE_E82A};

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .busy(busy), .done(done), .err(err)
  );

  imem_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_1000)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_last(in_last),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .count(count4),
    .busy(busy4), .done(done4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [5:0] f, input logic last);
    in_rs = rs; in_rt = rt; in_rd = rd; in_funct = f; in_last = last;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset.in_ready got %b want 0", in_ready); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset.mem_we got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset.mem_addr got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset.mem_wdata got %h want 0", mem_wdata); end
    vectors++; if ({busy, done, err} !== 3'b000) begin miscompares++; $display("FAIL reset.flags got %b want 000", {busy, done, err}); end
    vectors++; if (count !== 16'd0) begin miscompares++; $display("FAIL reset.count got %0d want 0", count); end
    vectors++; if (mem_addr4 !== 32'h0000_1000) begin miscompares++; $display("FAIL reset.mem_addr4 got %h want 00001000", mem_addr4); end
  endtask

  task automatic test_single();
    pulse_start();
    vectors++; if ({busy, in_ready} !== 2'b11) begin miscompares++; $display("FAIL single.open got %b want 11", {busy, in_ready}); end
    set_bundle(5'd1, 5'd2, 5'd3, 6'h20, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL single.we got %b want 1", mem_we); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL single.addr got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0022_1820) begin miscompares++; $display("FAIL single.wdata got %h want 00221820", mem_wdata); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL single.ready_drop got %b want 0", in_ready); end
    tick();
    vectors++; if ({mem_we, busy, done, err} !== 4'b0010) begin miscompares++; $display("FAIL single.end got %b want 0010", {mem_we, busy, done, err}); end
    vectors++; if (count !== 16'd1) begin miscompares++; $display("FAIL single.count got %0d want 1", count); end
    vectors++; if (mem_wdata !== 32'h0022_1820) begin miscompares++; $display("FAIL single.hold got %h want 00221820", mem_wdata); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      set_bundle(tb_rs[i], tb_rt[i], tb_rd[i], tb_funct[i], (i == 5));
      in_valid = 1'b1;
      tick();
      vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL b2b.we[%0d] got %b want 1", i, mem_we); end
      vectors++; if (mem_addr !== 32'(4 * i)) begin miscompares++; $display("FAIL b2b.addr[%0d] got %h want %h", i, mem_addr, 32'(4 * i)); end
      vectors++; if (mem_wdata !== tb_word[i]) begin miscompares++; $display("FAIL b2b.wdata[%0d] got %h want %h", i, mem_wdata, tb_word[i]); end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if ({mem_we, busy, done} !== 3'b001) begin miscompares++; $display("FAIL b2b.end got %b want 001", {mem_we, busy, done}); end
    vectors++; if (count !== 16'd6) begin miscompares++; $display("FAIL b2b.count got %0d want 6", count); end
  endtask

  task automatic test_illegal();
    pulse_start();
    set_bundle(5'd7, 5'd8, 5'd9, 6'h00, 1'b0);
    in_valid = 1'b1;
    tick();
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL illegal.no_write got %b want 0", mem_we); end
    vectors++; if ({err, in_ready} !== 2'b11) begin miscompares++; $display("FAIL illegal.err_ready got %b want 11", {err, in_ready}); end
    vectors++; if (count !== 16'd0) begin miscompares++; $display("FAIL illegal.count got %0d want 0", count); end
    set_bundle(5'd1, 5'd2, 5'd3, 6'h20, 1'b1);
    tick();
    in_valid = 1'b0;
    vectors++; if ({mem_we, mem_addr} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL illegal.second got we=%b addr=%h want 1/0", mem_we, mem_addr); end
    tick();
    vectors++; if ({done, err, count} !== {1'b1, 1'b1, 16'd1}) begin miscompares++; $display("FAIL illegal.end got done=%b err=%b count=%0d want 1/1/1", done, err, count); end
  endtask

  task automatic test_full();
    int idx;
    int writes;
    logic acc;
    idx = 0; writes = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_bundle(tb_rs[idx], tb_rt[idx], tb_rd[idx], 6'h20, 1'b0);
      in_valid4 = (idx < 5);
      acc = in_valid4 && in_ready4;
      tick();
      if (mem_we4) writes++;
      if (acc) begin
        idx++;
        if (idx == 4) begin
          vectors++; if (in_ready4 !== 1'b0) begin miscompares++; $display("FAIL full.ready_drop got %b want 0", in_ready4); end
          vectors++; if (mem_addr4 !== 32'h0000_100C) begin miscompares++; $display("FAIL full.addr4 got %h want 0000100c", mem_addr4); end
          vectors++; if (mem_wdata4 !== 32'h0064_2820) begin miscompares++; $display("FAIL full.wdata4 got %h want 00642820", mem_wdata4); end
        end
      end
    end
    in_valid4 = 1'b0;
    vectors++; if (writes !== 4) begin miscompares++; $display("FAIL full.writes got %0d want 4", writes); end
    vectors++; if (idx !== 4) begin miscompares++; $display("FAIL full.accepted got %0d want 4", idx); end
    vectors++; if ({done4, busy4, count4} !== {1'b1, 1'b0, 16'd4}) begin miscompares++; $display("FAIL full.end got done=%b busy=%b count=%0d want 1/0/4", done4, busy4, count4); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    set_bundle(5'd1, 5'd2, 5'd3, 6'h22, 1'b0);
    in_valid = 1'b1;
    tick();
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rstmid.pre_we got %b want 1", mem_we); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    vectors++; if ({mem_we, in_ready, busy, done, err} !== 5'b00000) begin miscompares++; $display("FAIL rstmid.flags got %b want 00000", {mem_we, in_ready, busy, done, err}); end
    vectors++; if ({mem_addr, mem_wdata, count} !== {32'h0, 32'h0, 16'd0}) begin miscompares++; $display("FAIL rstmid.regs got addr=%h wdata=%h count=%0d want 0/0/0", mem_addr, mem_wdata, count); end
    pulse_start();
    set_bundle(5'd4, 5'd5, 5'd6, 6'h27, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0, 32'h0085_3027}) begin miscompares++; $display("FAIL rstmid.restart got we=%b addr=%h wdata=%h want 1/0/00853027", mem_we, mem_addr, mem_wdata); end
    tick();
  endtask

  task automatic test_start_ignored();
    pulse_start();
    set_bundle(5'd1, 5'd2, 5'd3, 6'h20, 1'b0);
    in_valid = 1'b1;
    tick();
    set_bundle(5'd1, 5'd2, 5'd3, 6'h3F, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if ({count, err, busy} !== {16'd1, 1'b1, 1'b1}) begin miscompares++; $display("FAIL startbusy.kept got count=%0d err=%b busy=%b want 1/1/1", count, err, busy); end
    set_bundle(5'd2, 5'd3, 5'd4, 6'h25, 1'b1);
    tick();
    in_valid = 1'b0;
    vectors++; if ({mem_we, mem_addr} !== {1'b1, 32'h4}) begin miscompares++; $display("FAIL startbusy.addr got we=%b addr=%h want 1/4", mem_we, mem_addr); end
    tick();
    vectors++; if ({done, count} !== {1'b1, 16'd2}) begin miscompares++; $display("FAIL startbusy.done got done=%b count=%0d want 1/2", done, count); end
    pulse_start();
    vectors++; if ({busy, done, err, in_ready, count} !== {4'b1001, 16'd0}) begin miscompares++; $display("FAIL startdone.reopen got b=%b d=%b e=%b r=%b count=%0d want 1/0/0/1/0", busy, done, err, in_ready, count); end
    set_bundle(5'd1, 5'd2, 5'd3, 6'h2A, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0, 32'h0022_182A}) begin miscompares++; $display("FAIL startdone.write got we=%b addr=%h wdata=%h want 1/0/0022182a", mem_we, mem_addr, mem_wdata); end
    tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; start4 = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
    set_bundle(5'd0, 5'd0, 5'd0, 6'h00, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_full();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
